// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, redirect/stall
// inputs from downstream and the IF/ID register outputs.
interface pc_fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;

  modport master (
    output pc,
    output if_id_inst,
    output if_id_pc_plus4,
    output if_id_valid,
    output halted,
    output misalign_err,
    input  inst,
    input  stall,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    input  pc,
    input  if_id_inst,
    input  if_id_pc_plus4,
    input  if_id_valid,
    input  halted,
    input  misalign_err,
    output inst,
    output stall,
    output redirect_valid,
    output redirect_target
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and a
// small INIT/RUN/HALT/ERROR controller with redirect and stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALT,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      S_INIT: begin
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          if (bus.redirect_target[1:0] == 2'b00) begin
            pc_d   = bus.redirect_target;
            inst_d = 32'h0;
          end else begin
            state_d = S_ERROR;
          end
        end else if (bus.stall) begin
          state_d = S_RUN;
        end else if (bus.inst == HALT_INST) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end else begin
          inst_d  = bus.inst;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end
      S_HALT:  valid_d = 1'b0;
      S_ERROR: valid_d = 1'b0;
      default: begin
        valid_d = 1'b0;
        state_d = S_ERROR;
      end
    endcase
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      pc4_q    <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_inst     = inst_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.halted         = halted_q;
  assign bus.misalign_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, random run
// against a reference model, and a wrap-around instance.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  logic        use_mem;
  logic [31:0] tbl_inst;

  always_comb begin
    bus.inst = tbl_inst;
    if (use_mem) bus.inst = mem[bus.pc[7:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        rv;
    logic [31:0] rt;
    logic [31:0] in;
    logic [31:0] e_pc;
    logic        e_v;
    logic        chk_d;
    logic [31:0] e_inst;
    logic [31:0] e_p4;
    logic        e_h;
    logic        e_e;
  } vec_t;

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113;
  localparam logic [31:0] I3 = 32'h0030_0193;
  localparam logic [31:0] I4 = 32'h0040_0213;

  vec_t tbl [$];

  // reference model state
  logic [31:0] m_pc, m_inst, m_p4;
  logic        m_v, m_h, m_e, m_fresh;

  task automatic model_step(input logic r, input logic s,
                            input logic rv, input logic [31:0] rt,
                            input logic [31:0] in);
    if (r) begin
      m_pc = 32'h0; m_inst = 32'h0; m_p4 = 32'h0;
      m_v = 1'b0; m_h = 1'b0; m_e = 1'b0; m_fresh = 1'b1;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      m_v = 1'b0;
    end else if (m_h || m_e) begin
      m_v = 1'b0;
    end else if (rv) begin
      m_v = 1'b0;
      if (rt % 4 == 0) begin
        m_pc = rt;
        m_inst = 32'h0;
      end else begin
        m_e = 1'b1;
      end
    end else if (s) begin
      m_v = m_v;
    end else if (in == HALTW) begin
      m_v = 1'b0;
      m_h = 1'b1;
    end else begin
      m_inst = in;
      m_p4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_v = 1'b1;
    end
  endtask

  task automatic add(input logic r, input logic s, input logic rv,
                     input logic [31:0] rt, input logic [31:0] in,
                     input logic [31:0] e_pc, input logic e_v,
                     input logic chk_d, input logic [31:0] e_inst,
                     input logic [31:0] e_p4, input logic e_h,
                     input logic e_e);
    vec_t v;
    v.r = r; v.s = s; v.rv = rv; v.rt = rt; v.in = in;
    v.e_pc = e_pc; v.e_v = e_v; v.chk_d = chk_d;
    v.e_inst = e_inst; v.e_p4 = e_p4; v.e_h = e_h; v.e_e = e_e;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    use_mem = 1'b0;
    tbl_inst = I0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus2.inst = I0;
    bus2.stall = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_target = 32'h0;

    //  r  s  rv rt      in     pc      v  cd inst p4      h  e
    add(1, 0, 0, 32'h0,  I0,    32'h0,  0, 1, 0,   32'h0,  0, 0);
    add(0, 0, 1, 32'h80, HALTW, 32'h0,  0, 1, 0,   32'h0,  0, 0);
    add(0, 0, 0, 32'h0,  I1,    32'h4,  1, 1, I1,  32'h4,  0, 0);
    add(0, 0, 0, 32'h0,  I2,    32'h8,  1, 1, I2,  32'h8,  0, 0);
    add(0, 1, 0, 32'h0,  I3,    32'h8,  1, 1, I2,  32'h8,  0, 0);
    add(0, 1, 0, 32'h0,  HALTW, 32'h8,  1, 1, I2,  32'h8,  0, 0);
    add(0, 1, 0, 32'h0,  I4,    32'h8,  1, 1, I2,  32'h8,  0, 0);
    add(0, 0, 0, 32'h0,  I3,    32'hC,  1, 1, I3,  32'hC,  0, 0);
    add(0, 1, 1, 32'h40, I4,    32'h40, 0, 0, 0,   0,      0, 0);
    add(0, 0, 0, 32'h0,  I1,    32'h44, 1, 1, I1,  32'h44, 0, 0);
    add(0, 0, 1, 32'hC,  I2,    32'hC,  0, 0, 0,   0,      0, 0);
    add(0, 0, 0, 32'h0,  HALTW, 32'hC,  0, 0, 0,   0,      1, 0);
    add(0, 0, 1, 32'h80, I1,    32'hC,  0, 0, 0,   0,      1, 0);
    add(0, 1, 0, 32'h0,  I1,    32'hC,  0, 0, 0,   0,      1, 0);
    add(1, 0, 0, 32'h0,  I1,    32'h0,  0, 1, 0,   32'h0,  0, 0);
    add(0, 0, 0, 32'h0,  I1,    32'h0,  0, 0, 0,   0,      0, 0);
    add(0, 0, 0, 32'h0,  I2,    32'h4,  1, 1, I2,  32'h4,  0, 0);
    add(0, 0, 1, 32'h42, I3,    32'h4,  0, 0, 0,   0,      0, 1);
    add(0, 0, 1, 32'h100,I3,    32'h4,  0, 0, 0,   0,      0, 1);
    add(0, 0, 0, 32'h0,  HALTW, 32'h4,  0, 0, 0,   0,      0, 1);
    add(1, 0, 0, 32'h0,  I1,    32'h0,  0, 1, 0,   32'h0,  0, 0);
    add(0, 0, 0, 32'h0,  I1,    32'h0,  0, 0, 0,   0,      0, 0);
    add(0, 0, 0, 32'h0,  I1,    32'h4,  1, 1, I1,  32'h4,  0, 0);
    add(1, 1, 1, 32'h40, I2,    32'h0,  0, 1, 0,   32'h0,  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      bus.stall = tbl[i].s;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_target = tbl[i].rt;
      tbl_inst = tbl[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), bus.pc, tbl[i].e_pc);
      chk($sformatf("v%0d valid", i), {31'h0, bus.if_id_valid},
          {31'h0, tbl[i].e_v});
      chk($sformatf("v%0d halted", i), {31'h0, bus.halted},
          {31'h0, tbl[i].e_h});
      chk($sformatf("v%0d misalign", i), {31'h0, bus.misalign_err},
          {31'h0, tbl[i].e_e});
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d inst", i), bus.if_id_inst, tbl[i].e_inst);
        chk($sformatf("v%0d pc4", i), bus.if_id_pc_plus4, tbl[i].e_p4);
      end
    end

    // wrap-around instance
    @(posedge clk);
    #1;
    chk("wrap reset pc", bus2.pc, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap init pc", bus2.pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap pc", bus2.pc, 32'h0);
    chk("wrap pc4", bus2.if_id_pc_plus4, 32'h0);
    chk("wrap valid", {31'h0, bus2.if_id_valid}, 32'h1);
    chk("wrap err", {31'h0, bus2.misalign_err}, 32'h0);

    // randomized run against the reference model
    for (int i = 0; i < 64; i++) begin
      mem[i] = ($urandom_range(0, 11) == 0) ? HALTW : $urandom;
      if (mem[i] == HALTW && $urandom_range(0, 1) == 0) mem[i] = I0;
    end
    use_mem = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      logic r, s, rv;
      logic [31:0] rt;
      r = (c == 0) || ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      rst = r;
      bus.stall = s;
      bus.redirect_valid = rv;
      bus.redirect_target = rt;
      #1;
      model_step(r, s, rv, rt, mem[m_pc[7:2]]);
      @(posedge clk);
      #1;
      chk("rnd pc", bus.pc, m_pc);
      chk("rnd valid", {31'h0, bus.if_id_valid}, {31'h0, m_v});
      chk("rnd halted", {31'h0, bus.halted}, {31'h0, m_h});
      chk("rnd misalign", {31'h0, bus.misalign_err}, {31'h0, m_e});
      if (m_v) begin
        chk("rnd inst", bus.if_id_inst, m_inst);
        chk("rnd pc4", bus.if_id_pc_plus4, m_p4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL provide parameter HALT_INST, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port pc, output, 32: current fetch address, driven to the instruction memory's combinational read port.
REQ-006 The block SHALL have port inst, input, 32: instruction returned combinationally by the instruction memory for pc in the same cycle.
REQ-007 The block SHALL have port stall, input, 1: decode hazard; hold pc and IF/ID contents.
REQ-008 The block SHALL have port redirect_valid, input, 1: taken branch, jump or jr resolved downstream.
REQ-009 The block SHALL have port redirect_target, input, 32: new fetch address when redirect_valid=1.
REQ-010 The block SHALL have port if_id_inst, output, 32: registered fetched instruction.
REQ-011 The block SHALL have port if_id_pc_plus4, output, 32: registered pc+4 of that instruction.
REQ-012 The block SHALL have port if_id_valid, output, 1: IF/ID register holds a real instruction.
REQ-013 The block SHALL have port halted, output, 1: fetch stopped by HALT_INST.
REQ-014 The block SHALL have port misalign_err, output, 1: fetch stopped by a misaligned redirect.

Function
REQ-015 The block SHALL implement states INIT, RUN, HALT, ERROR; halted=1 only in HALT, misalign_err=1 only in ERROR, both registered.
REQ-016 INIT SHALL last exactly one cycle: pc held, if_id_valid=0, next state RUN unconditionally; inputs ignored.
REQ-017 In RUN the block SHALL apply priority redirect_valid > stall > HALT_INST detect > normal advance.
REQ-018 RUN with redirect_valid=1 and redirect_target[1:0]=2'b00 SHALL load pc<=redirect_target, if_id_valid<=0, if_id_inst<=32'h0 (one-bubble flush), even when stall=1.
REQ-019 RUN with redirect_valid=1 and redirect_target[1:0]!=2'b00 SHALL hold pc, clear if_id_valid, and enter ERROR.
REQ-020 RUN with stall=1 and no redirect SHALL hold pc, if_id_inst, if_id_pc_plus4 and if_id_valid unchanged.
REQ-021 RUN with inst==HALT_INST, no redirect, no stall SHALL hold pc, set if_id_valid<=0 (halt word not issued), enter HALT.
REQ-022 Normal advance SHALL latch if_id_inst<=inst, if_id_pc_plus4<=pc+4, if_id_valid<=1, pc<=pc+4; fetch-to-IF/ID latency one cycle.
REQ-023 pc+4 SHALL be computed modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-024 HALT and ERROR SHALL be terminal until rst: pc held, if_id_valid=0, redirect_valid and stall ignored.
REQ-025 pc[1:0] SHALL always be 2'b00 when RESET_PC is word-aligned; memory is indexed by pc[31:2].

Reset
REQ-026 rst=1 at a rising edge SHALL set pc=RESET_PC, state=INIT, if_id_inst=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, misalign_err=0, overriding all other inputs including mid-redirect, mid-stall, HALT and ERROR.

Verification
REQ-027 Reset then 4 cycles free-run with non-halt insts -> pc sequence 0,0,4,8,C; if_id_valid rises the cycle after INIT with if_id_pc_plus4=4.
REQ-028 redirect_valid=1, target=32'h40 while stall=1 -> next cycle pc=32'h40, if_id_valid=0; following cycle if_id_pc_plus4=32'h44, if_id_valid=1.
REQ-029 stall=1 for 3 cycles at pc=32'h8 -> pc, if_id_inst, if_id_pc_plus4 unchanged all 3 cycles; advance resumes on release.
REQ-030 inst=32'hFFFF_FFFF at pc=32'hC -> halted=1 next cycle, pc stays 32'hC, if_id_valid=0; later redirects ignored; rst recovers pc=0, halted=0.
REQ-031 redirect_target=32'h42 -> misalign_err=1 next cycle, pc held, if_id_valid=0 until rst.
REQ-032 RESET_PC=32'hFFFF_FFFC, free-run -> pc wraps to 32'h0000_0000 after first advance, if_id_pc_plus4=32'h0.
